// File: rtl/score_bcd_updown_if.sv
// Score register bus: award/penalty pulses in, BCD digits and flags out.
interface score_bcd_updown_if;
    logic       pOne;
    logic       pTwo;
    logic       pThree;
    logic       mOne;
    logic       mTwo;
    logic       mThree;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic       atZero;
    logic       atMax;
    logic       floorHit;
    logic       ceilHit;

    // Game logic side: issues pulses, watches the score.
    modport master (
        output pOne, pTwo, pThree, mOne, mTwo, mThree,
        input  bcd0, bcd1, bcd2, atZero, atMax, floorHit, ceilHit
    );

    // Score register side.
    modport slave (
        input  pOne, pTwo, pThree, mOne, mTwo, mThree,
        output bcd0, bcd1, bcd2, atZero, atMax, floorHit, ceilHit
    );
endinterface

// File: rtl/score_bcd_updown.sv
// Three-digit BCD up/down score register with +-1/2/3 steps, saturating
// at 000 and 999. Digits feed seg7 decoders directly.
module score_bcd_updown (
    input  logic                clk,
    input  logic                reset,
    score_bcd_updown_if.slave   sif
);

    logic [3:0]        d0, d1, d2;
    logic [3:0]        d0_nxt, d1_nxt, d2_nxt;
    logic              floor_hit_q, ceil_hit_q;
    logic              floor_nxt, ceil_nxt;

    logic [2:0]        award;
    logic [2:0]        penalty;
    logic signed [3:0] step_n;
    logic signed [4:0] ones_sum, tens_sum, hund_sum;
    logic signed [4:0] ones_adj, tens_adj;
    logic signed [1:0] c_ones, c_tens;

    // Net step and the ones->tens->hundreds carry/borrow chain, with clamping.
    always_comb begin
        award   = 3'd0;
        penalty = 3'd0;
        if (sif.pOne)        award = 3'd1;
        else if (sif.pTwo)   award = 3'd2;
        else if (sif.pThree) award = 3'd3;
        if (sif.mOne)        penalty = 3'd1;
        else if (sif.mTwo)   penalty = 3'd2;
        else if (sif.mThree) penalty = 3'd3;

        step_n = $signed({1'b0, award}) - $signed({1'b0, penalty});

        ones_sum = $signed({1'b0, d0}) + {step_n[3], step_n};
        ones_adj = ones_sum;
        c_ones   = 2'sd0;
        if (ones_sum > 5'sd9) begin
            ones_adj = ones_sum - 5'sd10;
            c_ones   = 2'sd1;
        end else if (ones_sum < 5'sd0) begin
            ones_adj = ones_sum + 5'sd10;
            c_ones   = -2'sd1;
        end

        tens_sum = $signed({1'b0, d1}) + {{3{c_ones[1]}}, c_ones};
        tens_adj = tens_sum;
        c_tens   = 2'sd0;
        if (tens_sum > 5'sd9) begin
            tens_adj = tens_sum - 5'sd10;
            c_tens   = 2'sd1;
        end else if (tens_sum < 5'sd0) begin
            tens_adj = tens_sum + 5'sd10;
            c_tens   = -2'sd1;
        end

        hund_sum = $signed({1'b0, d2}) + {{3{c_tens[1]}}, c_tens};

        d0_nxt    = ones_adj[3:0];
        d1_nxt    = tens_adj[3:0];
        d2_nxt    = hund_sum[3:0];
        floor_nxt = 1'b0;
        ceil_nxt  = 1'b0;
        // A hundreds overflow/underflow means the true result left 000..999.
        if (hund_sum > 5'sd9) begin
            d0_nxt   = 4'd9;
            d1_nxt   = 4'd9;
            d2_nxt   = 4'd9;
            ceil_nxt = 1'b1;
        end else if (hund_sum < 5'sd0) begin
            d0_nxt    = 4'd0;
            d1_nxt    = 4'd0;
            d2_nxt    = 4'd0;
            floor_nxt = 1'b1;
        end
    end

    // Digit registers and one-cycle clamp pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0          <= 4'd0;
            d1          <= 4'd0;
            d2          <= 4'd0;
            floor_hit_q <= 1'b0;
            ceil_hit_q  <= 1'b0;
        end else begin
            d0          <= d0_nxt;
            d1          <= d1_nxt;
            d2          <= d2_nxt;
            floor_hit_q <= floor_nxt;
            ceil_hit_q  <= ceil_nxt;
        end
    end

    assign sif.bcd0     = d0;
    assign sif.bcd1     = d1;
    assign sif.bcd2     = d2;
    assign sif.atZero   = (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);
    assign sif.atMax    = (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);
    assign sif.floorHit = floor_hit_q;
    assign sif.ceilHit  = ceil_hit_q;

endmodule

// File: tb/tb_score_bcd_updown.sv
// Bench for score_bcd_updown: integer saturating model feeds a scoreboard
// queue; each scenario task pops and compares after every stepped edge.
module tb_score_bcd_updown;

    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] P1   = 6'b000001;
    localparam logic [5:0] P2   = 6'b000010;
    localparam logic [5:0] P3   = 6'b000100;
    localparam logic [5:0] M1   = 6'b001000;
    localparam logic [5:0] M2   = 6'b010000;
    localparam logic [5:0] M3   = 6'b100000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    score_bcd_updown_if sif();
    score_bcd_updown dut (.clk(clk), .reset(reset), .sif(sif));

    int          total = 0;
    int          bad   = 0;
    int          model = 0;
    logic [15:0] sb[$];
    logic [15:0] got, exp_v;

    // {bcd2, bcd1, bcd0, atZero, atMax, floorHit, ceilHit}
    function automatic logic [15:0] exp_vec(int s, logic f, logic c);
        int h, t, o;
        h = s / 100;
        t = (s / 10) % 10;
        o = s % 10;
        return {h[3:0], t[3:0], o[3:0], (s == 0), (s == 999), f, c};
    endfunction

    function automatic logic [15:0] obs();
        return {sif.bcd2, sif.bcd1, sif.bcd0, sif.atZero, sif.atMax, sif.floorHit, sif.ceilHit};
    endfunction

    task automatic drive(input logic [5:0] v);
        {sif.mThree, sif.mTwo, sif.mOne, sif.pThree, sif.pTwo, sif.pOne} = v;
    endtask

    // Called at a negedge; applies one pulse across one rising edge and
    // returns at the following negedge with the expectation queued.
    task automatic step(input logic [5:0] v);
        int a, s, t;
        logic f, c;
        a = v[0] ? 1 : v[1] ? 2 : v[2] ? 3 : 0;
        s = v[3] ? 1 : v[4] ? 2 : v[5] ? 3 : 0;
        t = model + a - s;
        f = (t < 0);
        c = (t > 999);
        if (f) t = 0;
        if (c) t = 999;
        model = t;
        sb.push_back(exp_vec(model, f, c));
        drive(v);
        @(posedge clk);
        #1 drive(IDLE);
        @(negedge clk);
    endtask

    task automatic go_to(input int target);
        int diff;
        while (model != target) begin
            diff = target - model;
            if (diff >= 3)       step(P3);
            else if (diff == 2)  step(P2);
            else if (diff == 1)  step(P1);
            else if (diff <= -3) step(M3);
            else if (diff == -2) step(M2);
            else                 step(M1);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        drive(IDLE);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (obs() !== exp_vec(0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs(), exp_vec(0, 1'b0, 1'b0));
        end
        reset = 1'b0;
        model = 0;
        go_to(457);
        total++;
        if (obs() !== exp_vec(457, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reach_457: got %h want %h", obs(), exp_vec(457, 1'b0, 1'b0));
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs() !== exp_vec(0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL async_clear: got %h want %h", obs(), exp_vec(0, 1'b0, 1'b0));
        end
        model = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_carry();
        go_to(98);
        step(P3);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL carry_098_p3: got %h want %h", got, exp_v); end
        go_to(999);
        step(P1);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL ceil_999_p1: got %h want %h", got, exp_v); end
        step(IDLE);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL ceil_clear: got %h want %h", got, exp_v); end
    endtask

    task automatic test_borrow();
        go_to(100);
        step(M1);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL borrow_100_m1: got %h want %h", got, exp_v); end
        go_to(2);
        step(M3);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL floor_002_m3: got %h want %h", got, exp_v); end
        step(IDLE);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL floor_clear: got %h want %h", got, exp_v); end
    endtask

    task automatic test_simultaneous();
        go_to(50);
        step(P2 | M3);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL sim_p2_m3: got %h want %h", got, exp_v); end
        go_to(50);
        step(P3 | M1);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL sim_p3_m1: got %h want %h", got, exp_v); end
        go_to(0);
        step(P1 | M1);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL sim_zero_hold: got %h want %h", got, exp_v); end
        go_to(999);
        step(P1 | M1);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL sim_max_hold: got %h want %h", got, exp_v); end
    endtask

    task automatic test_priority();
        go_to(10);
        step(P1 | P3);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL prio_p1_p3: got %h want %h", got, exp_v); end
        step(M2 | M3);
        exp_v = sb.pop_front(); got = obs(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL prio_m2_m3: got %h want %h", got, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq [6];
        seq = '{P3, P3, P2, M3, M3, M3};
        go_to(997);
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            exp_v = sb.pop_front(); got = obs(); total++;
            if (got !== exp_v) begin bad++; $display("FAIL b2b_%0d: got %h want %h", i, got, exp_v); end
        end
        go_to(1);
        for (int i = 0; i < 3; i++) begin
            step(M2);
            exp_v = sb.pop_front(); got = obs(); total++;
            if (got !== exp_v) begin bad++; $display("FAIL b2b_floor_%0d: got %h want %h", i, got, exp_v); end
        end
    endtask

    task automatic test_sweep();
        int mag;
        logic up;
        logic [5:0] v;
        for (int i = 0; i < 2000; i++) begin
            up  = (i < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            mag = $urandom_range(0, 3);
            if (mag == 0) v = IDLE;
            else if (up)  v = 6'(1 << (mag - 1));
            else          v = 6'(1 << (mag + 2));
            step(v);
            exp_v = sb.pop_front(); got = obs(); total++;
            if (got !== exp_v || sif.bcd0 > 4'd9 || sif.bcd1 > 4'd9 || sif.bcd2 > 4'd9) begin
                bad++;
                $display("FAIL sweep_%0d: got %h want %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_borrow();
        test_simultaneous();
        test_priority();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
